// File: rtl/mano_pkg.sv
// mano_pkg: shared types and constants for the Mano CPU boot memory.
package mano_pkg;
    typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_e;
    localparam int MANO_WORD_W = 16;
    localparam int MEM_ADDR_W = 12;
    localparam logic [7:0] PAD_BYTE = 8'h00;
endpackage

// File: rtl/mano_boot_mem_if.sv
// mano_boot_mem_if: loader byte stream and CPU memory bus bundled together.
interface mano_boot_mem_if;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        cpu_run;
    logic        load_err;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we_n;
    logic [15:0] cpu_rdata;
    modport master (output ld_valid, ld_data, ld_last, cpu_addr, cpu_wdata, cpu_we_n,
                    input ld_ready, cpu_run, load_err, cpu_rdata);
    modport slave (input ld_valid, ld_data, ld_last, cpu_addr, cpu_wdata, cpu_we_n,
                   output ld_ready, cpu_run, load_err, cpu_rdata);
endinterface

// File: rtl/mano_ram.sv
// mano_ram: word array with one synchronous write port and one asynchronous read port.
module mano_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/mano_boot_mem.sv
// mano_boot_mem: boot loader packing a byte stream into words, then CPU-facing RAM.
module mano_boot_mem
    import mano_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_W,
    parameter int DATA_WIDTH = MANO_WORD_W,
    parameter int START_ADDR = 0
) (
    input  logic clk,
    input  logic reset,
    mano_boot_mem_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] START = ADDR_WIDTH'(START_ADDR);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            hi_q, hi_d;
    logic                  err_q, err_d, ready_q, run_q;
    logic                  xfer, ld_we, ram_we;
    logic [15:0]           ld_wdata;
    logic [15:0]           unused_addr;

    assign xfer = bus.ld_valid && ready_q;
    assign unused_addr = bus.cpu_addr;

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        hi_d = hi_q;
        err_d = err_q;
        ld_we = 1'b0;
        ld_wdata = {hi_q, bus.ld_data};
        if (xfer && state_q == LOAD_HI) begin
            hi_d = bus.ld_data;
            ld_wdata = {bus.ld_data, PAD_BYTE};
            ld_we = bus.ld_last;
            err_d = err_q | bus.ld_last;
            state_d = bus.ld_last ? RUN : LOAD_LO;
        end else if (xfer && state_q == LOAD_LO) begin
            ld_we = 1'b1;
            waddr_d = waddr_q + 1'b1;
            // Wrapping back onto the first loaded word means the image overran memory.
            err_d = err_q | (waddr_d == START);
            state_d = bus.ld_last ? RUN : LOAD_HI;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD_HI;
            waddr_q <= START;
            hi_q <= '0;
            err_q <= 1'b0;
            ready_q <= 1'b1;
            run_q <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            hi_q <= hi_d;
            err_q <= err_d;
            ready_q <= state_d != RUN;
            run_q <= state_d == RUN;
        end
    end

    assign ram_we = run_q ? !bus.cpu_we_n : ld_we;

    mano_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (run_q ? bus.cpu_addr[ADDR_WIDTH-1:0] : waddr_q),
        .wdata (run_q ? bus.cpu_wdata : ld_wdata),
        .raddr (bus.cpu_addr[ADDR_WIDTH-1:0]),
        .rdata (bus.cpu_rdata)
    );

    assign bus.ld_ready = ready_q;
    assign bus.cpu_run = run_q;
    assign bus.load_err = err_q;
endmodule

// File: tb/tb_mano_boot_mem.sv
// tb_mano_boot_mem: scoreboard bench for the boot loader, CPU port and overflow wrap.
module tb_mano_boot_mem;
    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    sb_t sb[$];
    logic [15:0] m_addr;
    logic [7:0] m_hi;
    bit m_pend;

    mano_boot_mem_if b0 ();
    mano_boot_mem_if b1 ();

    mano_boot_mem dut (.clk(clk), .reset(reset), .bus(b0));
    mano_boot_mem #(.ADDR_WIDTH(2)) dut_small (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        m_pend = 1'b0;
        m_addr = 16'h0;
    endtask

    task automatic send(input bit s, input logic [7:0] d, input bit last);
        if (s) begin
            b1.ld_valid = 1'b1; b1.ld_data = d; b1.ld_last = last;
        end else begin
            b0.ld_valid = 1'b1; b0.ld_data = d; b0.ld_last = last;
            if (m_pend) begin
                sb.push_back('{a: m_addr, d: {m_hi, d}});
                m_addr++;
                m_pend = 1'b0;
            end else if (last) begin
                sb.push_back('{a: m_addr, d: {d, 8'h00}});
            end else begin
                m_hi = d;
                m_pend = 1'b1;
            end
        end
        sync();
        b0.ld_valid = 1'b0; b0.ld_last = 1'b0;
        b1.ld_valid = 1'b0; b1.ld_last = 1'b0;
    endtask

    task automatic drain(input string tag);
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            b0.cpu_addr = e.a;
            #1;
            check(tag, b0.cpu_rdata, e.d);
        end
    endtask

    initial begin
        logic [7:0] img [6];
        b0.ld_valid = 0; b0.ld_data = 0; b0.ld_last = 0;
        b0.cpu_addr = 0; b0.cpu_wdata = 0; b0.cpu_we_n = 1;
        b1.ld_valid = 0; b1.ld_data = 0; b1.ld_last = 0;
        b1.cpu_addr = 0; b1.cpu_wdata = 0; b1.cpu_we_n = 1;
        sync();
        do_reset();
        check("rst_ready", b0.ld_ready, 1);
        check("rst_run", b0.cpu_run, 0);
        check("rst_err", b0.load_err, 0);

        img = '{8'h72, 8'h00, 8'h70, 8'h20, 8'h00, 8'h10};
        for (int i = 0; i < 5; i++) send(0, img[i], 0);
        check("run_before_last", b0.cpu_run, 0);
        send(0, img[5], 1);
        check("run_after_last", b0.cpu_run, 1);
        check("ready_after_last", b0.ld_ready, 0);
        check("basic_err", b0.load_err, 0);
        drain("basic_mem");

        sync();
        b0.cpu_addr = 16'h0010; b0.cpu_wdata = 16'h1111; b0.cpu_we_n = 0;
        sync();
        b0.cpu_wdata = 16'hBEEF;
        #1;
        check("store_old", b0.cpu_rdata, 16'h1111);
        sync();
        b0.cpu_we_n = 1;
        check("store_new", b0.cpu_rdata, 16'hBEEF);
        b0.cpu_addr = 16'hF010;
        #1;
        check("store_alias", b0.cpu_rdata, 16'hBEEF);

        do_reset();
        b0.cpu_addr = 16'h0010; b0.cpu_wdata = 16'h5555; b0.cpu_we_n = 0;
        sync();
        b0.cpu_we_n = 1;
        #1;
        check("cpu_wr_in_load", b0.cpu_rdata, 16'hBEEF);
        send(0, 8'hAB, 1);
        check("odd_err", b0.load_err, 1);
        check("odd_run", b0.cpu_run, 1);
        drain("odd_mem");

        do_reset();
        send(0, 8'hDE, 0);
        do_reset();
        send(0, 8'h11, 0);
        send(0, 8'h22, 1);
        check("midrst_err", b0.load_err, 0);
        check("midrst_run", b0.cpu_run, 1);
        drain("midrst_mem");

        do_reset();
        img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) begin
                b0.ld_data = 8'($urandom);
                sync();
            end
            check("thr_ready", b0.ld_ready, 1);
            send(0, img[i], i == 3);
        end
        check("thr_run", b0.cpu_run, 1);
        drain("thr_mem");

        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1, 8'hC0 + 8'(i), 0);
            send(1, 8'h10 + 8'(i), i == 4);
            check($sformatf("ovf_err%0d", i), b1.load_err, i >= 3);
        end
        check("ovf_run", b1.cpu_run, 1);
        b1.cpu_addr = 16'h0000;
        #1;
        check("ovf_mem0", b1.cpu_rdata, 16'hC414);
        b1.cpu_addr = 16'h0003;
        #1;
        check("ovf_mem3", b1.cpu_rdata, 16'hC313);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
